// File: rtl/cache_mem_pkg.sv
// Shared definitions for the cache hierarchy backing memory: FSM encodings,
// the memory init pattern base and small elaboration-time helpers.
package cache_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    WRITE = 2'd3
  } state_e;

  localparam logic [31:0] MEM_INIT_BASE = 32'hCAFE_0000;

  // Ceiling log2 for elaboration-time sizing.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  // Counter width that stays at least one bit wide.
  function automatic int cnt_width(input int n);
    return (clog2(n) > 0) ? clog2(n) : 1;
  endfunction

  // Number of data beats that make up one line.
  function automatic int calc_beats(input int block_size, input int data_width);
    return block_size * 8 / data_width;
  endfunction

endpackage

// File: rtl/mem_array_1rw.sv
// Single-port word array with combinational read. Every word powers up as
// MEM_INIT_BASE + word index. With MEM_WRITE_EN defined a synchronous write
// port is added; otherwise the contents are constant.
module mem_array_1rw
  import cache_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 9
) (
`ifdef MEM_WRITE_EN
  input  logic                  clk,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] wdata,
`endif
  input  logic [ADDR_BITS-1:0]  addr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] init_word;

  // Initial content of the addressed word, truncated to the word width.
  always_comb begin
    init_word = DATA_WIDTH'(MEM_INIT_BASE) + DATA_WIDTH'(addr);
  end

`ifdef MEM_WRITE_EN
  localparam int MEM_WORDS = 1 << ADDR_BITS;

  // Storage holds the XOR difference from the init pattern, so an all-zero
  // power-up state reads back as the pattern without any load sequence.
  logic [DATA_WIDTH-1:0] delta [MEM_WORDS] = '{default: '0};

  // Synchronous write; the array is deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (we) delta[addr] <= wdata ^ init_word;
  end

  assign rdata = init_word ^ delta[addr];
`else
  assign rdata = init_word;
`endif

endmodule

// File: rtl/main_memory_responder.sv
// Backing-memory responder for L2 line fills. Accepts one line request,
// waits LATENCY cycles, then streams the line as BEATS words with a last
// marker. Optional feature macro: MEM_WRITE_EN (single-word writes with a
// one-cycle wr_done acknowledge).
module main_memory_responder
  import cache_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int BLOCK_SIZE = 32,
  parameter int LATENCY    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
`ifdef MEM_WRITE_EN
  input  logic                  req_we,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  wr_done,
`endif
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_last,
  output logic                  busy
);

  localparam int BYTE_W = clog2(DATA_WIDTH / 8);
  localparam int OFF_W  = clog2(BLOCK_SIZE);
  localparam int BEATS  = calc_beats(BLOCK_SIZE, DATA_WIDTH);
  localparam int LB     = clog2(BEATS);
  localparam int BW     = cnt_width(BEATS);
  localparam int LAT_W  = cnt_width(LATENCY);
  localparam int WAW    = ADDR_WIDTH - BYTE_W;
  localparam int LW     = ADDR_WIDTH - OFF_W;

  state_e                state;
  logic [LW-1:0]         line_q;
  logic [LAT_W-1:0]      lat_cnt;
  logic [BW-1:0]         beat_cnt;
  logic [BW-1:0]         rd_beat;
  logic [WAW-1:0]        rd_word;
  logic [WAW-1:0]        mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  addr_unused;

  // Offset bits inside a line never select anything.
  assign addr_unused = ^req_addr[OFF_W-1:0];

  // Beat to be loaded into resp_data at the next edge: first beat when
  // leaving WAIT, the following beat while bursting.
  always_comb begin
    rd_beat = (state == BURST) ? beat_cnt + BW'(1) : '0;
    rd_word = (WAW'(line_q) << LB) | WAW'(rd_beat);
  end

`ifdef MEM_WRITE_EN
  logic                  is_wr_q;
  logic [WAW-1:0]        wa_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  mem_we;

  assign mem_we   = (state == WAIT) && is_wr_q && (lat_cnt == '0);
  assign mem_addr = ((state == WAIT) && is_wr_q) ? wa_q : rd_word;

  mem_array_1rw #(.DATA_WIDTH(DATA_WIDTH), .ADDR_BITS(WAW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .wdata (wdata_q),
    .addr  (mem_addr),
    .rdata (mem_rdata)
  );
`else
  assign mem_addr = rd_word;

  mem_array_1rw #(.DATA_WIDTH(DATA_WIDTH), .ADDR_BITS(WAW)) u_mem (
    .addr  (mem_addr),
    .rdata (mem_rdata)
  );
`endif

  // Request/latency/burst FSM with all handshake outputs registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_last  <= 1'b0;
      busy       <= 1'b0;
      line_q     <= '0;
      lat_cnt    <= '0;
      beat_cnt   <= '0;
`ifdef MEM_WRITE_EN
      wr_done    <= 1'b0;
      is_wr_q    <= 1'b0;
      wa_q       <= '0;
      wdata_q    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            line_q    <= req_addr[ADDR_WIDTH-1:OFF_W];
            lat_cnt   <= LAT_W'(LATENCY - 1);
            state     <= WAIT;
            req_ready <= 1'b0;
            busy      <= 1'b1;
`ifdef MEM_WRITE_EN
            is_wr_q   <= req_we;
            wa_q      <= req_addr[ADDR_WIDTH-1:BYTE_W];
            wdata_q   <= req_wdata;
`endif
          end
        end
        WAIT: begin
          if (lat_cnt == '0) begin
`ifdef MEM_WRITE_EN
            if (is_wr_q) begin
              state   <= WRITE;
              wr_done <= 1'b1;
            end else begin
              state      <= BURST;
              resp_valid <= 1'b1;
              resp_data  <= mem_rdata;
              resp_last  <= (rd_beat == BW'(BEATS - 1));
              beat_cnt   <= '0;
            end
`else
            state      <= BURST;
            resp_valid <= 1'b1;
            resp_data  <= mem_rdata;
            resp_last  <= (rd_beat == BW'(BEATS - 1));
            beat_cnt   <= '0;
`endif
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        BURST: begin
          if (resp_ready) begin
            if (resp_last) begin
              state      <= IDLE;
              resp_valid <= 1'b0;
              resp_last  <= 1'b0;
              resp_data  <= '0;
              req_ready  <= 1'b1;
              busy       <= 1'b0;
            end else begin
              beat_cnt  <= rd_beat;
              resp_data <= mem_rdata;
              resp_last <= (rd_beat == BW'(BEATS - 1));
            end
          end
        end
        WRITE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
`ifdef MEM_WRITE_EN
          wr_done   <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_main_memory_responder.sv
// Self-checking bench for main_memory_responder: a cycle-level transaction
// model checked every cycle, plus directed scenarios with literal values.
module tb_main_memory_responder;

  localparam int LAT = 8;

  typedef struct {
    logic        last;
    logic [31:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        resp_ready = 1'b1;
  logic        req_we = 1'b0;
  logic [10:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, resp_valid, resp_last, busy, wr_done;
  logic [31:0] resp_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int last_cyc = 0;
  beat_t got_q[$];

  // Transaction model state
  logic [31:0] mem_m [512];
  logic [31:0] exp_q[$];
  bit          m_busy = 0, m_valid = 0, m_wr = 0, m_wrdone = 0;
  int          m_cnt = 0, m_waddr = 0;
  logic [31:0] m_wdata = '0;

  main_memory_responder dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
`ifdef MEM_WRITE_EN
    .req_we     (req_we),
    .req_wdata  (req_wdata),
    .wr_done    (wr_done),
`endif
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_last  (resp_last),
    .busy       (busy)
  );

`ifndef MEM_WRITE_EN
  assign wr_done = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < 512; i++) mem_m[i] = 32'hCAFE_0000 + i;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Every-cycle compare against the model, then advance the model by the
  // inputs that the coming edge will sample.
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("req_ready", req_ready, !m_busy);
      chk("busy", busy, m_busy);
      chk("resp_valid", resp_valid, m_valid);
      chk("wr_done", wr_done, m_wrdone);
      if (m_valid) begin
        chk("resp_data", resp_data, exp_q[0]);
        chk("resp_last", resp_last, exp_q.size() == 1);
      end
    end
    if (rst && resp_valid && resp_ready) begin
      got_q.push_back('{last: resp_last, data: resp_data});
      if (resp_last) last_cyc = cyc;
    end
    if (!rst) begin
      m_busy = 0; m_valid = 0; m_wrdone = 0; m_wr = 0; m_cnt = 0;
      exp_q.delete();
    end else if (m_wrdone) begin
      m_wrdone = 0;
      m_busy = 0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy = 1;
        m_cnt = LAT;
`ifdef MEM_WRITE_EN
        m_wr = req_we;
`endif
        m_waddr = int'(req_addr) >> 2;
        m_wdata = req_wdata;
        exp_q.delete();
        if (!m_wr)
          for (int k = 0; k < 8; k++) exp_q.push_back(mem_m[(int'(req_addr) >> 5) * 8 + k]);
      end
    end else if (!m_valid) begin
      m_cnt--;
      if (m_cnt == 0) begin
        if (m_wr) begin
          mem_m[m_waddr] = m_wdata;
          m_wrdone = 1;
        end else begin
          m_valid = 1;
        end
      end
    end else if (resp_ready) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) begin
        m_valid = 0;
        m_busy = 0;
      end
    end
  end

  task automatic send(input logic [10:0] a, input logic we, input logic [31:0] wd);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    req_addr = a; req_we = we; req_wdata = wd; req_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk); #1;
        acc_cyc = cyc;
        ok = 1;
        break;
      end
    end
    req_valid = 1'b0; req_we = 1'b0;
    chk("accept_timeout", ok, 1'b1);
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = cyc - acc_cyc;
        break;
      end
    end
  endtask

  task automatic wait_beats(input int n);
    for (int i = 0; i < 300 && got_q.size() < n; i++) @(posedge clk);
    chk("beat_count", got_q.size(), n);
    #1;
  endtask

  task automatic chk_line(input int off, input logic [31:0] base);
    for (int k = 0; k < 8; k++) begin
      chk("line_data", got_q[off + k].data, base + k);
      chk("line_last", got_q[off + k].last, k == 7);
    end
  endtask

  initial begin
    int lat;
    bit any_last;

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b1;

    // Plain line read of 0x045 -> words 0x10..0x17
    got_q.delete();
    send(11'h045, 1'b0, 32'h0);
    wait_valid(lat);
    chk("read_latency", lat, 8);
    wait_beats(8);
    chk_line(0, 32'hCAFE_0010);

    // Back-pressure on beat 3 for five cycles
    got_q.delete();
    send(11'h045, 1'b0, 32'h0);
    wait_valid(lat);
    chk("bp_latency", lat, 8);
    repeat (3) @(posedge clk);
    #1 resp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_data", resp_data, 32'hCAFE_0013);
      chk("bp_hold_valid", resp_valid, 1'b1);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    wait_beats(8);
    chk_line(0, 32'hCAFE_0010);

    // Second request held while busy, accepted right after the last beat
    got_q.delete();
    send(11'h045, 1'b0, 32'h0);
    send(11'h0A0, 1'b0, 32'h0);
    chk("busy_accept_gap", acc_cyc - last_cyc, 2);
    wait_beats(16);
    chk_line(0, 32'hCAFE_0010);
    chk_line(8, 32'hCAFE_0028);

    // Reset while beat 4 is on the bus
    got_q.delete();
    send(11'h045, 1'b0, 32'h0);
    wait_valid(lat);
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_valid", resp_valid, 1'b0);
    chk("abort_last", resp_last, 1'b0);
    chk("abort_ready", req_ready, 1'b1);
    chk("abort_beats", got_q.size(), 4);
    any_last = 0;
    foreach (got_q[i]) any_last |= got_q[i].last;
    chk("abort_no_last", any_last, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    got_q.delete();
    send(11'h000, 1'b0, 32'h0);
    wait_beats(8);
    chk_line(0, 32'hCAFE_0000);

`ifdef MEM_WRITE_EN
    // Word write then line read-back
    send(11'h048, 1'b1, 32'hDEAD_BEEF);
    lat = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (wr_done) begin
        lat = cyc - acc_cyc;
        break;
      end
    end
    chk("wr_latency", lat, 8);
    @(negedge clk);
    chk("wr_done_pulse", wr_done, 1'b0);
    got_q.delete();
    send(11'h040, 1'b0, 32'h0);
    wait_beats(8);
    for (int k = 0; k < 8; k++)
      chk("wr_readback", got_q[k].data, (k == 2) ? 32'hDEAD_BEEF : 32'hCAFE_0010 + k);
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
